// File: rtl/score_pkg.sv
// Shared types and default constants for the foosball score-digit path.
package score_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    PAUSE     = 2'd1,
    GAME_OVER = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10
  } winner_t;

  localparam int unsigned DEF_WIN_SCORE    = 5;
  localparam int unsigned DEF_PAUSE_FRAMES = 60;
  localparam int unsigned DEF_LEVEL2_SCORE = 3;

  function automatic logic [3:0] max_digit(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/score_controller_if.sv
// Game-side strobes into the score controller and score/status values out of it.
interface score_controller_if;
  logic       startOfFrame;
  logic       goal_left;
  logic       goal_right;
  logic       new_game;
  logic [3:0] digit_left;
  logic [3:0] digit_right;
  logic       freeze_play;
  logic       score_pulse;
  logic       scoreLevel1;
  logic       scoreLevel2;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output startOfFrame, goal_left, goal_right, new_game,
    input  digit_left, digit_right, freeze_play, score_pulse,
           scoreLevel1, scoreLevel2, game_over, winner
  );

  modport slave (
    input  startOfFrame, goal_left, goal_right, new_game,
    output digit_left, digit_right, freeze_play, score_pulse,
           scoreLevel1, scoreLevel2, game_over, winner
  );
endinterface

// File: rtl/goal_edge_detect.sv
// Registered rising-edge detector: a held goal level yields exactly one rise.
module goal_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic level,
  output logic rise
);
  logic level_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) level_d <= 1'b0;
    else         level_d <= level;
  end

  assign rise = level & ~level_d;
endmodule

// File: rtl/score_controller.sv
// Turns goal strobes into score digits and runs the play / pause / game-over phases.
module score_controller
  import score_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
  parameter int unsigned PAUSE_FRAMES = DEF_PAUSE_FRAMES,
  parameter int unsigned LEVEL2_SCORE = DEF_LEVEL2_SCORE
) (
  input logic               clk,
  input logic               resetN,
  score_controller_if.slave bus
);
  localparam logic [3:0] WIN_D    = 4'(WIN_SCORE);
  localparam logic [3:0] LEVEL2_D = 4'(LEVEL2_SCORE);
  localparam logic [7:0] PAUSE_D  = 8'(PAUSE_FRAMES);

  game_state_t state;
  winner_t     winner;
  logic [3:0]  digit_left, digit_right;
  logic [7:0]  pause_cnt;
  logic        freeze_play, score_pulse, level1, level2, game_over;
  logic        rise_left, rise_right;
  logic [3:0]  next_left, next_right;
  logic        hit_win, hit_level2;

  goal_edge_detect u_edge_left  (.clk(clk), .resetN(resetN), .level(bus.goal_left),  .rise(rise_left));
  goal_edge_detect u_edge_right (.clk(clk), .resetN(resetN), .level(bus.goal_right), .rise(rise_right));

  // Left has priority on a simultaneous rise; the right rise is simply dropped.
  always_comb begin
    next_left  = digit_left;
    next_right = digit_right;
    if (rise_left)       next_left  = digit_left + 4'd1;
    else if (rise_right) next_right = digit_right + 4'd1;
    hit_win    = (next_left == WIN_D) || (next_right == WIN_D);
    hit_level2 = max_digit(next_left, next_right) >= LEVEL2_D;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= PLAY;
      winner      <= WIN_NONE;
      digit_left  <= '0;
      digit_right <= '0;
      pause_cnt   <= '0;
      freeze_play <= 1'b0;
      score_pulse <= 1'b0;
      level1      <= 1'b1;
      level2      <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      score_pulse <= 1'b0;
      if (bus.new_game) begin
        state       <= PLAY;
        winner      <= WIN_NONE;
        digit_left  <= '0;
        digit_right <= '0;
        pause_cnt   <= '0;
        freeze_play <= 1'b0;
        level1      <= 1'b1;
        level2      <= 1'b0;
        game_over   <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (rise_left || rise_right) begin
              digit_left  <= next_left;
              digit_right <= next_right;
              score_pulse <= 1'b1;
              freeze_play <= 1'b1;
              if (hit_win) begin
                state     <= GAME_OVER;
                winner    <= rise_left ? WIN_LEFT : WIN_RIGHT;
                game_over <= 1'b1;
                level1    <= 1'b0;
                level2    <= 1'b0;
              end else begin
                state     <= PAUSE;
                pause_cnt <= PAUSE_D;
                level1    <= ~hit_level2;
                level2    <= hit_level2;
              end
            end
          end
          PAUSE: begin
            if (bus.startOfFrame) begin
              pause_cnt <= pause_cnt - 8'd1;
              if (pause_cnt == 8'd1) begin
                state       <= PLAY;
                freeze_play <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  a_digit_range: assert property (@(posedge clk) disable iff (!resetN)
    (digit_left <= WIN_D) && (digit_right <= WIN_D));

  assign bus.digit_left  = digit_left;
  assign bus.digit_right = digit_right;
  assign bus.freeze_play = freeze_play;
  assign bus.score_pulse = score_pulse;
  assign bus.scoreLevel1 = level1;
  assign bus.scoreLevel2 = level2;
  assign bus.game_over   = game_over;
  assign bus.winner      = winner;
endmodule

// File: tb/tb_score_controller.sv
// Directed scenarios plus random goal/frame/new-game traffic against a score-rule model.
module tb_score_controller;
  localparam int WIN = 5;
  localparam int PF  = 3;
  localparam int L2  = 3;

  logic clk = 1'b0;
  logic resetN;
  int   n_checks = 0;
  int   n_fail   = 0;

  score_controller_if bus ();

  score_controller #(.WIN_SCORE(WIN), .PAUSE_FRAMES(PF), .LEVEL2_SCORE(L2)) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: scores and phase flags, updated from the game rules.
  int m_left, m_right, m_winner, m_frames;
  bit m_paused, m_over, m_pulse, m_prev_l, m_prev_r;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    int  hi;
    bit  lv2;
    hi  = (m_left > m_right) ? m_left : m_right;
    lv2 = !m_over && (hi >= L2);
    check_val("digit_left",  bus.digit_left,  m_left);
    check_val("digit_right", bus.digit_right, m_right);
    check_val("freeze_play", bus.freeze_play, m_paused || m_over);
    check_val("score_pulse", bus.score_pulse, m_pulse);
    check_val("game_over",   bus.game_over,   m_over);
    check_val("winner",      bus.winner,      m_winner);
    check_val("scoreLevel2", bus.scoreLevel2, lv2);
    check_val("scoreLevel1", bus.scoreLevel1, !m_over && !lv2);
  endtask

  task automatic step(input bit gl, input bit gr, input bit sof, input bit ng);
    bit rl, rr;
    @(negedge clk);
    bus.goal_left    = gl;
    bus.goal_right   = gr;
    bus.startOfFrame = sof;
    bus.new_game     = ng;
    rl = gl && !m_prev_l;
    rr = gr && !m_prev_r;
    m_prev_l = gl;
    m_prev_r = gr;
    m_pulse  = 0;
    if (ng) begin
      m_left = 0; m_right = 0; m_winner = 0; m_frames = 0;
      m_paused = 0; m_over = 0;
    end else if (!m_over) begin
      if (m_paused) begin
        if (sof) begin
          m_frames--;
          if (m_frames == 0) m_paused = 0;
        end
      end else if (rl || rr) begin
        if (rl) m_left++;
        else    m_right++;
        m_pulse = 1;
        if (m_left == WIN)       begin m_over = 1; m_winner = 1; end
        else if (m_right == WIN) begin m_over = 1; m_winner = 2; end
        else                     begin m_paused = 1; m_frames = PF; end
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic score(input bit left);
    step(0, 0, 0, 0);
    step(left, !left, 0, 0);
  endtask

  task automatic finish_pause();
    step(0, 0, 0, 0);
    repeat (PF) step(0, 0, 1, 0);
  endtask

  initial begin
    int pulses;
    bit gl, gr;
    resetN = 1'b0;
    bus.goal_left = 0; bus.goal_right = 0; bus.startOfFrame = 0; bus.new_game = 0;
    m_left = 0; m_right = 0; m_winner = 0; m_frames = 0;
    m_paused = 0; m_over = 0; m_pulse = 0; m_prev_l = 0; m_prev_r = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_digit_left",  bus.digit_left,  0);
    check_val("rst_digit_right", bus.digit_right, 0);
    check_val("rst_freeze",      bus.freeze_play, 0);
    check_val("rst_level1",      bus.scoreLevel1, 1);
    check_val("rst_level2",      bus.scoreLevel2, 0);
    check_val("rst_winner",      bus.winner,      0);
    @(negedge clk);
    resetN = 1'b1;

    // Held goal level: one score, one pulse, then frozen.
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 0);
      if (i == 0) check_val("t1_digit_left", bus.digit_left, 1);
      pulses += int'(bus.score_pulse);
    end
    check_val("t1_pulse_count", pulses, 1);
    check_val("t1_freeze", bus.freeze_play, 1);

    // Pause exit after PF frames; right goal during pause is ignored.
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    check_val("t2_freeze_before", bus.freeze_play, 1);
    step(0, 1, 1, 0);
    check_val("t2_freeze_after", bus.freeze_play, 0);
    step(0, 1, 0, 0);
    check_val("t2_digit_right", bus.digit_right, 0);

    // Simultaneous rises: left only.
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    check_val("t3_digit_left",  bus.digit_left,  2);
    check_val("t3_digit_right", bus.digit_right, 0);
    check_val("t3_pulse",       bus.score_pulse, 1);
    finish_pause();

    // Left runs to the winning score.
    score(1); finish_pause();
    score(1); finish_pause();
    score(1);
    check_val("t4_digit_left", bus.digit_left,  5);
    check_val("t4_game_over",  bus.game_over,   1);
    check_val("t4_winner",     bus.winner,      1);
    check_val("t4_freeze",     bus.freeze_play, 1);
    score(1); score(0);
    check_val("t4_hold_left",  bus.digit_left,  5);
    check_val("t4_hold_right", bus.digit_right, 0);

    // new_game mid-pause, and new_game beating a coincident goal.
    step(0, 0, 0, 1);
    check_val("t5_after_over", bus.game_over, 0);
    score(1); finish_pause();
    score(0); finish_pause();
    score(1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    check_val("t5_left",   bus.digit_left,  0);
    check_val("t5_right",  bus.digit_right, 0);
    check_val("t5_freeze", bus.freeze_play, 0);
    step(1, 0, 0, 1);
    check_val("t5_coinc_left", bus.digit_left,  0);
    check_val("t5_coinc_pulse", bus.score_pulse, 0);

    // Level-2 threshold and levels cleared in game over.
    score(0); finish_pause();
    score(0); finish_pause();
    score(0);
    check_val("t6_level2", bus.scoreLevel2, 1);
    check_val("t6_level1", bus.scoreLevel1, 0);
    finish_pause();
    score(0); finish_pause();
    score(0);
    check_val("t6_winner",   bus.winner,      2);
    check_val("t6_over_l1",  bus.scoreLevel1, 0);
    check_val("t6_over_l2",  bus.scoreLevel2, 0);
    step(0, 0, 0, 1);

    // Random traffic.
    gl = 0; gr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) gl = !gl;
      if ($urandom_range(0, 5) == 0) gr = !gr;
      step(gl, gr, $urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
